// File: rtl/gate_truth_checker.sv
// gate_truth_checker: walks every input combination of a small combinational
// gate-under-test in ascending order. Each vector is held for SETTLE_CYCLES
// cycles and then compared once against EXPECT_TT. The checker reports the
// number of mismatches, the first failing vector and an overall pass flag.
//
// Handshake: start is a level qualifier. It is sampled only in IDLE or DONE,
// and any rising edge that sees start=1 there begins a new run on that edge.
// While busy=1 the checker ignores start. done stays high, and every result
// holds, until the next start.
module gate_truth_checker #(
    parameter int                    N_IN          = 2,
    parameter int                    SETTLE_CYCLES = 2,
    parameter logic [(2**N_IN)-1:0]  EXPECT_TT     = 4'b1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            gate_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid,
    output logic [1:0]      fsm_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]      CNT_ONE     = 8'd1;
    localparam logic [N_IN-1:0] STIM_LAST   = '1;
    localparam logic [N_IN-1:0] STIM_ONE    = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

    logic [1:0]    state;
    logic [7:0]    cnt;
    logic          mismatch;
    logic [N_IN:0] err_next;

    // The debug view of the FSM is the state register itself.
    assign fsm_state = state;

    // This block compares the current vector and forms the error count that
    // includes it. gate_y matters only in SAMPLE, so X values outside SAMPLE
    // are masked out here.
    always_comb begin
        mismatch = 1'b0;
        err_next = err_count;
        if (state == ST_SAMPLE) begin
            mismatch = (gate_y != EXPECT_TT[stim]);
        end
        if (mismatch) begin
            err_next = err_count + ERR_ONE;
        end
    end

    // This block holds the sequencer state, the stimulus and every reported
    // result. All outputs come from registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // A restart from DONE behaves exactly like a start from IDLE.
                    if (start) begin
                        state           <= ST_SETTLE;
                        cnt             <= '0;
                        stim            <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && !first_err_valid) begin
                        first_err_vec   <= stim;
                        first_err_valid <= 1'b1;
                    end
                    if (stim == STIM_LAST) begin
                        // The final compare is already folded into err_next.
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        stim  <= stim + STIM_ONE;
                        state <= ST_SETTLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Testbench for gate_truth_checker. It runs the default 2-input instance
// against several software gates from a vector table, then exercises the
// multi-cycle corner cases by hand. A 3-input instance covers the
// stuck-at-0 case.
module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start3;
    logic [1:0] gut_mode;

    logic [1:0] stim;
    logic       gate_y, busy, done, pass, first_err_valid;
    logic [2:0] err_count;
    logic [1:0] first_err_vec;
    logic [1:0] fsm_state;

    logic [2:0] stim3;
    logic       gate_y3, busy3, done3, pass3, first_err_valid3;
    logic [3:0] err_count3;
    logic [2:0] first_err_vec3;
    logic [1:0] fsm_state3;

    int n_tests = 0;
    int n_fail  = 0;

    // clock
    always #5 clk = ~clk;

    // software gate-under-test: 0 AND, 1 NAND, 2 OR, 3 XOR
    always_comb begin
        case (gut_mode)
            2'd0:    gate_y = stim[0] & stim[1];
            2'd1:    gate_y = ~(stim[0] & stim[1]);
            2'd2:    gate_y = stim[0] | stim[1];
            default: gate_y = stim[0] ^ stim[1];
        endcase
    end

    // 3-input AND whose output is stuck at 0
    assign gate_y3 = 1'b0;

    gate_truth_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .gate_y(gate_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid),
        .fsm_state(fsm_state)
    );

    gate_truth_checker #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECT_TT(8'h80)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .stim(stim3), .gate_y(gate_y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
        .first_err_vec(first_err_vec3), .first_err_valid(first_err_valid3),
        .fsm_state(fsm_state3)
    );

    typedef struct {
        logic [1:0] mode;
        bit         poke;
        logic [2:0] e_err;
        logic [1:0] e_first;
        logic       e_fv;
        logic       e_pass;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full default run. The task starts and ends on a negedge. When poke
    // is set, start is raised again at edges 4 and 8 while the run is busy.
    task automatic run_default(input vec_t v);
        gut_mode = v.mode;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("clr_err", 32'(err_count), 0);
        check("clr_fv", 32'(first_err_valid), 0);
        check("clr_pass", 32'(pass), 0);
        for (int k = 0; k < 12; k++) begin
            check("run_stim", 32'(stim), 32'(k / 3));
            check("run_busy", 32'(busy), 1);
            check("run_done", 32'(done), 0);
            start = (v.poke && (k == 3 || k == 7)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("end_done", 32'(done), 1);
        check("end_busy", 32'(busy), 0);
        check("end_err", 32'(err_count), 32'(v.e_err));
        check("end_first", 32'(first_err_vec), 32'(v.e_first));
        check("end_fv", 32'(first_err_valid), 32'(v.e_fv));
        check("end_pass", 32'(pass), 32'(v.e_pass));
        check("end_stim", 32'(stim), 3);
        // DONE holds its results while start stays low.
        @(negedge clk);
        @(negedge clk);
        check("hold_done", 32'(done), 1);
        check("hold_err", 32'(err_count), 32'(v.e_err));
        check("hold_stim", 32'(stim), 3);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{mode: 2'd0, poke: 1'b0, e_err: 3'd0, e_first: 2'd0, e_fv: 1'b0, e_pass: 1'b1};
        vecs[1] = '{mode: 2'd1, poke: 1'b0, e_err: 3'd4, e_first: 2'd0, e_fv: 1'b1, e_pass: 1'b0};
        vecs[2] = '{mode: 2'd2, poke: 1'b1, e_err: 3'd2, e_first: 2'd1, e_fv: 1'b1, e_pass: 1'b0};
        vecs[3] = '{mode: 2'd3, poke: 1'b0, e_err: 3'd3, e_first: 2'd1, e_fv: 1'b1, e_pass: 1'b0};
        vecs[4] = '{mode: 2'd0, poke: 1'b0, e_err: 3'd0, e_first: 2'd0, e_fv: 1'b0, e_pass: 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        start3   = 1'b0;
        gut_mode = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        check("rst_stim", 32'(stim), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_first", 32'(first_err_vec), 0);
        check("rst_fv", 32'(first_err_valid), 0);
        check("rst_state", 32'(fsm_state), 0);
        check("rst3_busy", 32'(busy3), 0);
        check("rst3_err", 32'(err_count3), 0);

        // Table runs. Each run after the first restarts directly from DONE.
        for (int i = 0; i < 5; i++) begin
            run_default(vecs[i]);
        end

        // Reset mid-run: NAND, rst_n low at edge 7 after the start edge.
        gut_mode = 2'd1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_err", 32'(err_count), 2);
        check("pre_rst_stim", 32'(stim), 2);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check("mid_rst_state", 32'(fsm_state), 0);
        check("mid_rst_stim", 32'(stim), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_err", 32'(err_count), 0);
        check("mid_rst_fv", 32'(first_err_valid), 0);
        check("mid_rst_done", 32'(done), 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 0);
        end

        // N_IN=3, SETTLE_CYCLES=1, output stuck at 0: only vector 7 mismatches.
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("n3_stim", 32'(stim3), 32'(k / 2));
            check("n3_done", 32'(done3), 0);
            @(negedge clk);
        end
        check("n3_end_done", 32'(done3), 1);
        check("n3_err", 32'(err_count3), 1);
        check("n3_first", 32'(first_err_vec3), 7);
        check("n3_fv", 32'(first_err_valid3), 1);
        check("n3_pass", 32'(pass3), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
Self-checking exerciser that sits directly upstream and downstream of a small combinational gate-under-test (GUT), for example an AND built from NAND plus NOT.
- Drives every input combination onto the GUT in ascending binary order.
- Waits a programmable settle time, then samples the GUT output and compares it with a parameterised expected truth table.
- Reports error count, first failing vector and pass/fail.
- Replaces hand-written stimulus sequences in gate-level benches and on-board bring-up.

Parameters:
N_IN, 2, number of GUT inputs (1..6).
SETTLE_CYCLES, 2, clock cycles each vector is held before sampling (1..255).
EXPECT_TT, 4'b1000, expected truth table, width 2**N_IN; bit i is the expected gate_y for stim==i (default is AND).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a run; sampled only in IDLE or DONE
stim  output  N_IN  registered vector driven to the GUT inputs; bit 0 is the first input (a)
gate_y  input  1  GUT output
busy  output  1  high in SETTLE and SAMPLE
done  output  1  high while in DONE
pass  output  1  valid when done=1; 1 if err_count==0
err_count  output  N_IN+1  number of mismatching vectors in the current or last run
first_err_vec  output  N_IN  index of the first mismatching vector; 0 if none
first_err_valid  output  1  set on the first mismatch of a run

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE and all of the following are cleared in the same edge, including mid-run:
  - stim=0, busy=0, done=0, pass=0
  - err_count=0, first_err_vec=0, first_err_valid=0
  - settle counter=0
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE to SETTLE on an edge with start=1:
  - stim<=0, cnt<=0
  - err_count, first_err_vec and first_err_valid cleared; pass<=0
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE and clear cnt.
  - stim is stable throughout.
- SAMPLE (one cycle), with gate_y sampled at the edge leaving SAMPLE:
  - On mismatch (gate_y != EXPECT_TT[stim]): err_count<=err_count+1.
  - On mismatch with first_err_valid==0: also first_err_vec<=stim and first_err_valid<=1.
  - If stim==2**N_IN-1, go to DONE, with pass<=(final err_count==0), counting the current compare.
  - Otherwise stim<=stim+1 and return to SETTLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - A full run takes (2**N_IN)*(SETTLE_CYCLES+1) cycles.
  - done rises on the edge that completes the last SAMPLE.
- DONE:
  - done=1; stim holds the last vector; results hold.
  - start=1 restarts exactly as from IDLE, with no intermediate IDLE cycle.
- start while busy: ignored, with no restart and no effect on results.
- err_count never wraps: its width N_IN+1 holds the maximum value 2**N_IN.
- gate_y is not compared outside SAMPLE; X or toggling there has no effect.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Defaults, GUT = AND of stim[1:0], start pulsed for 1 cycle after reset:
   - stim steps 0,1,2,3, each held for 3 cycles.
   - done rises 12 edges after the start edge.
   - pass=1, err_count=0, first_err_valid=0.
2. Defaults, GUT = NAND:
   - All 4 vectors mismatch.
   - err_count=4, first_err_vec=0, first_err_valid=1, pass=0.
3. Defaults, GUT = OR:
   - Vectors 1 and 2 mismatch.
   - err_count=2, first_err_vec=1, pass=0.
4. Reset mid-run: assert rst_n=0 for 1 cycle at edge 7 after start (during vector 2):
   - Next cycle: state IDLE, stim=0, busy=0, err_count=0.
   - With no new start, busy stays 0 for 20 cycles.
5. start re-pulsed at edges 4 and 8 during a run:
   - Run completes at edge 12 unchanged.
   - From DONE, start with GUT switched to AND: results clear on that edge and a second run gives pass=1 after 12 edges.
6. N_IN=3, SETTLE_CYCLES=1, EXPECT_TT=8'h80, GUT = 3-input AND with its output stuck at 0:
   - done after 16 edges.
   - err_count=1, first_err_vec=7.
